// File: rtl/cell_core_gen.sv
// Per-cell SIMD execution core: register file, neighbour/coordinate sources,
// multi-cycle multiply and a private predication stack for nested IF/ELSE/ENDIF.
module cell_core_gen #(
   parameter int DATA_W      = 8,
   parameter int NREGS       = 8,
   parameter int MOORE       = 0,
   parameter int STACK_DEPTH = 4,
   parameter int MUL_LAT     = 2,
   parameter int X           = 0,
   parameter int Y           = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  global_enable,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [3:0]            opcode,
   input  logic [4:0]            target,
   input  logic [4:0]            src_a,
   input  logic [4:0]            src_b,
   input  logic [DATA_W-1:0]     imm,
   input  logic [DATA_W-1:0]     my_in,
   input  logic [8*DATA_W-1:0]   nbr_in,
   output logic [DATA_W-1:0]     next_state,
   output logic [DATA_W-1:0]     next_video,
   output logic                  diverge,
   output logic                  err
);

   localparam int CW  = $clog2(MUL_LAT + 1);
   localparam int SPW = $clog2(STACK_DEPTH + 1);

   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_OR    = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_SHL   = 4'd6;
   localparam logic [3:0] OP_SHR   = 4'd7;
   localparam logic [3:0] OP_LI    = 4'd8;
   localparam logic [3:0] OP_MOV   = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_IF    = 4'd11;
   localparam logic [3:0] OP_ELSE  = 4'd12;
   localparam logic [3:0] OP_ENDIF = 4'd13;

   localparam logic [4:0]        NREGS_IDX = 5'(NREGS);
   localparam logic [4:0]        IDX_VIDEO = 5'd19;
   localparam logic [SPW-1:0]    SP_FULL   = SPW'(STACK_DEPTH);
   localparam logic [DATA_W-1:0] DW_VAL    = DATA_W'(DATA_W);

   logic [DATA_W-1:0]      regs [16];
   logic [DATA_W-1:0]      video;
   logic [STACK_DEPTH-1:0] stk;
   logic [SPW-1:0]         sp;
   logic                   active;

   logic [CW-1:0]          mul_cnt;
   logic [DATA_W-1:0]      mul_a, mul_b, mul_res;
   logic [4:0]             mul_tgt;
   logic                   mul_act, mul_done, mul_commit;

   logic [DATA_W-1:0]      a_val, b_val, t_val, alu_res;
   logic                   issue, alu_op, commit;
   logic                   wr_en;
   logic [4:0]             wr_idx;
   logic [DATA_W-1:0]      wr_data;

   function automatic logic [DATA_W-1:0] read_src(input logic [4:0] idx);
      logic [2:0] k;
      k        = 3'(idx - 5'd20);
      read_src = '0;
      if (idx == 5'd0)
         read_src = my_in;
      else if (idx <= 5'd15) begin
         if (idx <= NREGS_IDX) read_src = regs[idx[3:0]];
      end else if (idx == 5'd17)
         read_src = DATA_W'(X);
      else if (idx == 5'd18)
         read_src = DATA_W'(Y);
      else if (idx == IDX_VIDEO)
         read_src = video;
      else if (idx >= 5'd20 && idx <= 5'd27) begin
         if (k < 3'd4 || MOORE != 0) read_src = nbr_in[int'(k)*DATA_W +: DATA_W];
      end
   endfunction

   always_comb begin
      a_val = read_src(src_a);
      b_val = read_src(src_b);
      t_val = read_src(target);
   end

   // Handshake: an instruction is taken on any cycle where instr_valid and
   // instr_ready are both high; instr_ready drops while a MUL is in flight or
   // the array is globally disabled, and the broadcaster must hold the fields.
   assign instr_ready = global_enable && (mul_cnt == '0);
   assign issue       = instr_valid && instr_ready;
   assign alu_op      = (opcode >= OP_ADD) && (opcode <= OP_MOV);
   assign commit      = issue && alu_op && active;

   always_comb begin
      active = 1'b1;
      for (int i = 0; i < STACK_DEPTH; i++)
         if (SPW'(i) < sp && !stk[i]) active = 1'b0;
   end

   always_comb begin
      alu_res = '0;
      case (opcode)
         OP_ADD: alu_res = a_val + b_val;
         OP_SUB: alu_res = a_val - b_val;
         OP_AND: alu_res = a_val & b_val;
         OP_OR:  alu_res = a_val | b_val;
         OP_XOR: alu_res = a_val ^ b_val;
         OP_SHL: alu_res = (b_val >= DW_VAL) ? '0 : (a_val << b_val);
         OP_SHR: alu_res = (b_val >= DW_VAL) ? '0 : (a_val >> b_val);
         OP_LI:  alu_res = imm;
         OP_MOV: alu_res = a_val;
         default: alu_res = '0;
      endcase
   end

   // The countdown only advances with global_enable, so a frozen MUL
   // completes on the first enabled cycle that sees a count of one.
   assign mul_res    = mul_a * mul_b;
   assign mul_done   = (mul_cnt == CW'(1)) && global_enable;
   assign mul_commit = mul_done && mul_act;

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      if (commit) begin
         wr_en   = 1'b1;
         wr_idx  = target;
         wr_data = alu_res;
      end else if (mul_commit) begin
         wr_en   = 1'b1;
         wr_idx  = mul_tgt;
         wr_data = mul_res;
      end
   end

   always_comb begin
      next_state = my_in;
      if (wr_en && wr_idx == 5'd0) next_state = wr_data;
   end

   assign next_video = video;
   assign diverge    = (sp != '0) && !active;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         video   <= '0;
         stk     <= '0;
         sp      <= '0;
         err     <= 1'b0;
         mul_cnt <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_tgt <= '0;
         mul_act <= 1'b0;
      end else begin
         if (wr_en) begin
            if (wr_idx != 5'd0 && wr_idx <= NREGS_IDX) regs[wr_idx[3:0]] <= wr_data;
            if (wr_idx == IDX_VIDEO) video <= wr_data;
         end

         if (issue && opcode == OP_MUL) begin
            mul_cnt <= CW'(MUL_LAT);
            mul_a   <= a_val;
            mul_b   <= b_val;
            mul_tgt <= target;
            mul_act <= active;
         end else if (mul_cnt != '0 && global_enable) begin
            mul_cnt <= mul_cnt - CW'(1);
         end

         if (issue) begin
            case (opcode)
               OP_IF: begin
                  if (sp == SP_FULL) err <= 1'b1;
                  else begin
                     for (int i = 0; i < STACK_DEPTH; i++)
                        if (SPW'(i) == sp) stk[i] <= (t_val != '0);
                     sp <= sp + SPW'(1);
                  end
               end
               OP_ELSE: begin
                  if (sp == '0) err <= 1'b1;
                  else
                     for (int i = 0; i < STACK_DEPTH; i++)
                        if (SPW'(i) == sp - SPW'(1)) stk[i] <= ~stk[i];
               end
               OP_ENDIF: begin
                  if (sp == '0) err <= 1'b1;
                  else sp <= sp - SPW'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule
